// File: rtl/apex7_pkg.sv
// Shared types and sizes for the apex7 frame sequencer.
package apex7_pkg;

  localparam int BULL_W = 7;
  localparam int CAT_N  = 6;
  localparam int IBT_W  = 3;

  // Thermometer-style codes, so the busy decode can look at individual bits.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0000,
    ST_ARM  = 4'b0001,
    ST_RUN  = 4'b0011,
    ST_HOLD = 4'b0111,
    ST_DONE = 4'b1111
  } star_e;

  function automatic logic is_busy(star_e s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/apex7_state_if.sv
// Pad-level bundle of the apex7 sequencer: inputs from the frame source, outputs back.
interface apex7_state_if;
  import apex7_pkg::*;

  logic              owl_n;
  logic              watch;
  logic              fbi;
  logic              end_s;
  logic [IBT_W-1:0]  ibt;
  logic [CAT_N-1:0]  cat;
  logic              del1;
  logic [BULL_W-1:0] bull;
  logic [3:0]        star;
  logic [CAT_N-1:0]  pluto;
  logic              accrpy;
  logic              kbg_n;
  logic              comppar;

  modport master (
    output owl_n, watch, fbi, end_s, ibt, cat, del1,
    input  bull, star, pluto, accrpy, kbg_n, comppar
  );

  modport slave (
    input  owl_n, watch, fbi, end_s, ibt, cat, del1,
    output bull, star, pluto, accrpy, kbg_n, comppar
  );

endinterface

// File: rtl/apex7_cat_sel.sv
// Category select: IBT values 2..7 pick CAT bit IBT-2; 0..1 select nothing.
module apex7_cat_sel
  import apex7_pkg::*;
(
  input  logic [IBT_W-1:0] ibt,
  input  logic [CAT_N-1:0] cat,
  output logic             cat_hit,
  output logic             idx_valid,
  output logic [CAT_N-1:0] idx_onehot
);

  for (genvar g = 0; g < CAT_N; g++) begin : g_dec
    assign idx_onehot[g] = (ibt == IBT_W'(g + 2));
  end

  // Six one-hot positions cover 2..7 exactly, so any hit means a valid index.
  assign idx_valid = |idx_onehot;
  assign cat_hit   = |(cat & idx_onehot);

endmodule

// File: rtl/apex7_state.sv
// Frame sequencer: arms on FBI, runs until END, captures the selected category.
// Optional running parity on COMPPAR_pad when APEX7_STATE_PARITY_EN is defined.
module apex7_state
  import apex7_pkg::*;
(
  input  logic              CLK_pad,
  input  logic              RST_N_pad,
  input  logic              OWL_N_pad,
  input  logic              WATCH_pad,
  input  logic              FBI_pad,
  input  logic              END_pad,
  input  logic [IBT_W-1:0]  IBT_pad,
  input  logic [CAT_N-1:0]  CAT_pad,
  input  logic              DEL1_pad,
  output logic [BULL_W-1:0] BULL_pad,
  output logic [3:0]        STAR_pad,
  output logic [CAT_N-1:0]  PLUTO_pad,
  output logic              ACCRPY_pad,
  output logic              KBG_N_pad,
  output logic              COMPPAR_pad
);

  star_e             state_q, state_d;
  logic [BULL_W-1:0] bull_q, bull_d;
  logic [CAT_N-1:0]  pluto_q, pluto_d;
  logic              accrpy_q, accrpy_d;
  logic              kbg_n_q, kbg_n_d;
  logic              comppar_q, comppar_d;

  logic              cat_hit;
  logic              idx_valid;
  logic [CAT_N-1:0]  idx_onehot;
  logic              par_tgl;

  apex7_cat_sel u_cat_sel (
    .ibt        (IBT_pad),
    .cat        (CAT_pad),
    .cat_hit    (cat_hit),
    .idx_valid  (idx_valid),
    .idx_onehot (idx_onehot)
  );

`ifdef APEX7_STATE_PARITY_EN
  assign par_tgl = FBI_pad & DEL1_pad;
`else
  logic unused_del1;
  assign unused_del1 = DEL1_pad;
  assign par_tgl     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bull_d    = bull_q;
    pluto_d   = pluto_q;
    accrpy_d  = 1'b0;
    comppar_d = comppar_q ^ par_tgl;
    if (!OWL_N_pad) begin
      state_d   = ST_IDLE;
      bull_d    = '0;
      pluto_d   = '0;
      comppar_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (FBI_pad) begin
          state_d = ST_ARM;
          bull_d  = '0;
        end
        ST_ARM: begin
          if (!FBI_pad)     state_d = ST_IDLE;
          else if (cat_hit) state_d = ST_RUN;
        end
        ST_RUN: begin
          // END still lets a same-cycle WATCH count before leaving RUN.
          if (WATCH_pad) bull_d  = bull_q + BULL_W'(1);
          if (END_pad)   state_d = ST_HOLD;
        end
        ST_HOLD: begin
          state_d  = ST_DONE;
          pluto_d  = idx_valid ? idx_onehot : '0;
          accrpy_d = 1'b1;
        end
        ST_DONE: if (!FBI_pad) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // Registered from next state so KBG_N lines up with STAR on the same edge.
    kbg_n_d = ~is_busy(state_d);
  end

  always_ff @(posedge CLK_pad or negedge RST_N_pad) begin
    if (!RST_N_pad) begin
      state_q   <= ST_IDLE;
      bull_q    <= '0;
      pluto_q   <= '0;
      accrpy_q  <= 1'b0;
      kbg_n_q   <= 1'b1;
      comppar_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bull_q    <= bull_d;
      pluto_q   <= pluto_d;
      accrpy_q  <= accrpy_d;
      kbg_n_q   <= kbg_n_d;
      comppar_q <= comppar_d;
    end
  end

  assign STAR_pad    = state_q;
  assign BULL_pad    = bull_q;
  assign PLUTO_pad   = pluto_q;
  assign ACCRPY_pad  = accrpy_q;
  assign KBG_N_pad   = kbg_n_q;
  assign COMPPAR_pad = comppar_q;

endmodule

// File: tb/tb_apex7_state.sv
// Directed + random bench for apex7_state against a phase-level reference model.
module tb_apex7_state;
  import apex7_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apex7_state_if bus ();

  apex7_state dut (
    .CLK_pad     (clk),
    .RST_N_pad   (rst_n),
    .OWL_N_pad   (bus.owl_n),
    .WATCH_pad   (bus.watch),
    .FBI_pad     (bus.fbi),
    .END_pad     (bus.end_s),
    .IBT_pad     (bus.ibt),
    .CAT_pad     (bus.cat),
    .DEL1_pad    (bus.del1),
    .BULL_pad    (bus.bull),
    .STAR_pad    (bus.star),
    .PLUTO_pad   (bus.pluto),
    .ACCRPY_pad  (bus.accrpy),
    .KBG_N_pad   (bus.kbg_n),
    .COMPPAR_pad (bus.comppar)
  );

`ifdef APEX7_STATE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Model: phase 0..4 = idle, arm, run, hold, done; observable code per phase.
  int          checks = 0;
  int          errors = 0;
  int          ph;
  int          m_bull;
  logic [5:0]  m_pluto;
  logic        m_acc;
  logic        m_par;
  int          code [5] = '{0, 1, 3, 7, 15};
  int          del_pat [4] = '{1, 0, 1, 1};
  int          par_exp [4] = '{1, 1, 0, 1};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; m_bull = 0; m_pluto = '0; m_acc = 1'b0; m_par = 1'b0;
  endtask

  task automatic model_edge();
    int  sel;
    bit  hit;
    logic [5:0] c;
    c   = bus.cat;
    sel = int'(bus.ibt) - 2;
    hit = (sel >= 0) && c[sel];
    if (!rst_n || !bus.owl_n) begin
      model_reset();
      return;
    end
    m_acc = 1'b0;
    if (PAR_EN && bus.fbi && bus.del1) m_par = ~m_par;
    case (ph)
      0: if (bus.fbi) begin ph = 1; m_bull = 0; end
      1: if (!bus.fbi) ph = 0; else if (hit) ph = 2;
      2: begin
        if (bus.watch) m_bull = (m_bull + 1) % 128;
        if (bus.end_s) ph = 3;
      end
      3: begin
        ph = 4; m_acc = 1'b1;
        m_pluto = (sel >= 0) ? 6'(1 << sel) : 6'd0;
      end
      default: if (!bus.fbi) ph = 0;
    endcase
  endtask

  task automatic check_all(string tag);
    check({tag, ".star"},    32'(bus.star),    32'(code[ph]));
    check({tag, ".bull"},    32'(bus.bull),    32'(m_bull));
    check({tag, ".pluto"},   32'(bus.pluto),   32'(m_pluto));
    check({tag, ".accrpy"},  32'(bus.accrpy),  32'(m_acc));
    check({tag, ".kbg_n"},   32'(bus.kbg_n),   (ph == 2 || ph == 3) ? 32'd0 : 32'd1);
    check({tag, ".comppar"}, 32'(bus.comppar), 32'(m_par));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.owl_n = 1'b1; bus.watch = 1'b0; bus.fbi = 1'b0; bus.end_s = 1'b0;
    bus.ibt = 3'd0; bus.cat = 6'd0; bus.del1 = 1'b0;
    do_reset();

    // Full frame: arm, run 5 counted cycles, capture idx 3.
    bus.fbi = 1'b1; bus.ibt = 3'b101; bus.cat = 6'b001000;
    step("f_arm");
    step("f_run");
    check("f_run_star", 32'(bus.star), 32'h3);
    bus.watch = 1'b1;
    repeat (4) step("f_cnt");
    bus.end_s = 1'b1;
    step("f_end");
    check("f_hold_star", 32'(bus.star), 32'h7);
    bus.watch = 1'b0; bus.end_s = 1'b0;
    step("f_cap");
    check("f_bull5", 32'(bus.bull), 32'd5);
    check("f_pluto", 32'(bus.pluto), 32'h08);
    check("f_acc1", 32'(bus.accrpy), 32'd1);
    step("f_done");
    check("f_acc_pulse", 32'(bus.accrpy), 32'd0);
    bus.fbi = 1'b0;
    step("f_idle");

    // Counter wrap over 130 cycles, then clear from HOLD.
    bus.fbi = 1'b1;
    step("w_arm");
    step("w_run");
    bus.watch = 1'b1;
    repeat (130) step("w_cnt");
    check("w_wrap", 32'(bus.bull), 32'd2);
    bus.end_s = 1'b1;
    step("w_hold");
    bus.owl_n = 1'b0; bus.end_s = 1'b0; bus.watch = 1'b0;
    step("owl");
    check("owl_star", 32'(bus.star), 32'd0);
    check("owl_acc", 32'(bus.accrpy), 32'd0);
    check("owl_pluto", 32'(bus.pluto), 32'd0);
    bus.owl_n = 1'b1;

    // Invalid select keeps ARM.
    step("i_arm");
    bus.ibt = 3'b001; bus.cat = 6'b111111;
    repeat (5) step("i_stay");
    check("i_star", 32'(bus.star), 32'd1);
    check("i_kbg", 32'(bus.kbg_n), 32'd1);

    // Async reset mid-RUN, between edges.
    bus.ibt = 3'b101; bus.cat = 6'b001000; bus.watch = 1'b1;
    step("a_run");
    repeat (3) step("a_cnt");
    #2; rst_n = 1'b0; #1;
    check("a_star", 32'(bus.star), 32'd0);
    check("a_bull", 32'(bus.bull), 32'd0);
    check("a_kbg", 32'(bus.kbg_n), 32'd1);
    check("a_pluto", 32'(bus.pluto), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    bus.watch = 1'b0; bus.fbi = 1'b0;
    step("a_after");

    // Parity pattern with FBI held and select invalid so ARM is stable.
    do_reset();
    bus.fbi = 1'b1; bus.ibt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      bus.del1 = del_pat[i][0];
      step("p_pat");
      check("p_comppar", 32'(bus.comppar), PAR_EN ? 32'(par_exp[i]) : 32'd0);
    end

    // Random traffic, occasional sync clear.
    for (int n = 0; n < 3000; n++) begin
      bus.owl_n = ($urandom_range(0, 59) != 0);
      bus.fbi   = ($urandom_range(0, 7) != 0);
      bus.watch = $urandom_range(0, 1) != 0;
      bus.end_s = ($urandom_range(0, 5) == 0);
      bus.ibt   = 3'($urandom_range(0, 7));
      bus.cat   = 6'($urandom);
      bus.del1  = $urandom_range(0, 1) != 0;
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
